// File: rtl/opl3_host_wr_queue_pkg.sv
// Shared types for the OPL3 host write queue: FSM state encoding and queued entry layout.
package opl3_host_wr_queue_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ADDR  = 3'd1,
    GAP_A = 3'd2,
    DATA  = 3'd3,
    GAP_D = 3'd4
  } wrq_state_t;

  // One complete register write; reg_idx is the register index within the bank.
  typedef struct packed {
    logic       bank;
    logic [7:0] reg_idx;
    logic [7:0] data;
  } wrq_entry_t;

endpackage

// File: rtl/opl3_host_wr_queue_if.sv
// Push channel into the write queue and the OPL3 host bus driven out of it.
interface opl3_host_wr_queue_if;
  logic       wr_valid;
  logic       wr_ready;
  logic       wr_bank;
  logic [7:0] wr_reg;
  logic [7:0] wr_data;

  modport master (output wr_valid, wr_bank, wr_reg, wr_data, input wr_ready);
  modport slave  (input wr_valid, wr_bank, wr_reg, wr_data, output wr_ready);
endinterface

interface opl3_host_bus_if;
  logic       cs_n;
  logic       rd_n;
  logic       wr_n;
  logic [1:0] address;
  logic [7:0] din;
  logic       ack_host_wr;

  modport master (output cs_n, rd_n, wr_n, address, din, input ack_host_wr);
  modport slave  (input cs_n, rd_n, wr_n, address, din, output ack_host_wr);
endinterface

// File: rtl/opl3_wr_fifo.sv
// Single-clock FIFO of register-write entries with an explicit occupancy counter.
module opl3_wr_fifo
  import opl3_host_wr_queue_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push,
  input  logic               pop,
  input  wrq_entry_t         din,
  output wrq_entry_t         dout,
  output logic [$clog2(DEPTH):0] level,
  output logic               full
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  wrq_entry_t    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  // Caller guarantees push only when not full and pop only when level != 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: level <= level;
      endcase
    end
  end

  assign dout = mem[rd_ptr];
  assign full = (level == FULL_LVL);

endmodule

// File: rtl/opl3_host_wr_queue.sv
// Queues OPL3 register writes and replays each as address strobe, gap, data strobe, gap.
// Optional ack timeout enabled by defining OPL3_WR_QUEUE_TIMEOUT_EN.
module opl3_host_wr_queue
  import opl3_host_wr_queue_pkg::*;
#(
  parameter int DEPTH          = 16,
  parameter int GAP_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                   clk_host,
  input  logic                   ic_n,
  opl3_host_wr_queue_if.slave    wr,
  opl3_host_bus_if.master        bus,
  output logic [$clog2(DEPTH):0] level,
  output logic                   busy,
  output logic                   timeout_err,
  output wrq_state_t             fsm_state
);
  localparam int CNT_MAX = (GAP_CYCLES > TIMEOUT_CYCLES) ? GAP_CYCLES : TIMEOUT_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  wrq_state_t    state, next_state;
  wrq_entry_t    push_entry, head, cur;
  logic          push, pop, full;
  logic [CW-1:0] cnt;
  logic          cnt_run, cnt_strobe, gap_hit, to_hit;
  logic          cs_n_q, wr_n_q;
  logic [1:0]    address_q;
  logic [7:0]    din_q;

  // Push handshake: an entry transfers on a clock edge where wr_valid && wr_ready;
  // wr_ready comes only from the registered level, and a refused producer holds its entry.
  assign wr.wr_ready = !full;
  assign push        = wr.wr_valid && wr.wr_ready;
  assign push_entry  = {wr.wr_bank, wr.wr_reg, wr.wr_data};

  opl3_wr_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk_host),
    .rst_n (ic_n),
    .push  (push),
    .pop   (pop),
    .din   (push_entry),
    .dout  (head),
    .level (level),
    .full  (full)
  );

`ifdef OPL3_WR_QUEUE_TIMEOUT_EN
  logic timeout_q;
  assign cnt_strobe = 1'b1;
  assign to_hit     = (cnt == CW'(TIMEOUT_CYCLES - 1));
  always_ff @(posedge clk_host or negedge ic_n) begin
    if (!ic_n) timeout_q <= 1'b0;
    else if ((state == ADDR || state == DATA) && !bus.ack_host_wr && to_hit) timeout_q <= 1'b1;
  end
  assign timeout_err = timeout_q;
`else
  assign cnt_strobe  = 1'b0;
  assign to_hit      = 1'b0;
  assign timeout_err = 1'b0;
`endif

  assign gap_hit = (cnt == CW'(GAP_CYCLES - 1));
  assign cnt_run = (state == GAP_A) || (state == GAP_D) ||
                   (cnt_strobe && (state == ADDR || state == DATA));

  always_comb begin
    next_state = state;
    pop        = 1'b0;
    case (state)
      IDLE: if (level != '0) begin
        pop        = 1'b1;
        next_state = ADDR;
      end
      ADDR: begin
        if (bus.ack_host_wr) next_state = GAP_A;
        else if (to_hit)     next_state = GAP_D;
      end
      GAP_A: if (gap_hit) next_state = DATA;
      DATA: begin
        if (bus.ack_host_wr) next_state = GAP_D;
        else if (to_hit)     next_state = GAP_D;
      end
      GAP_D: if (gap_hit) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // The counter restarts on every state change, so each phase begins at zero.
  always_ff @(posedge clk_host or negedge ic_n) begin
    if (!ic_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= next_state;
      cnt   <= (cnt_run && next_state == state) ? cnt + CW'(1) : '0;
    end
  end

  // Strobes are registered from next_state so they track the state register cycle for cycle.
  always_ff @(posedge clk_host or negedge ic_n) begin
    if (!ic_n) begin
      cs_n_q    <= 1'b1;
      wr_n_q    <= 1'b1;
      address_q <= '0;
      din_q     <= '0;
      cur       <= '0;
    end else begin
      cs_n_q <= !(next_state == ADDR || next_state == DATA);
      wr_n_q <= !(next_state == ADDR || next_state == DATA);
      if (pop) begin
        cur       <= head;
        address_q <= {head.bank, 1'b0};
        din_q     <= head.reg_idx;
      end else if (state == GAP_A && next_state == DATA) begin
        address_q <= {cur.bank, 1'b1};
        din_q     <= cur.data;
      end
    end
  end

  assign bus.cs_n    = cs_n_q;
  assign bus.wr_n    = wr_n_q;
  assign bus.rd_n    = 1'b1;
  assign bus.address = address_q;
  assign bus.din     = din_q;

  assign busy      = (state != IDLE) || (level != '0);
  assign fsm_state = state;

endmodule

// File: tb/tb_opl3_host_wr_queue.sv
// Directed bench for opl3_host_wr_queue: bus responder with scoreboard plus cycle-exact checks.
module tb_opl3_host_wr_queue;
  import opl3_host_wr_queue_pkg::*;

  logic       clk;
  logic       ic_n;
  logic [4:0] level;
  logic       busy;
  logic       timeout_err;
  wrq_state_t fsm_state;

  opl3_host_wr_queue_if wr_if ();
  opl3_host_bus_if      bus_if ();

  opl3_host_wr_queue #(.DEPTH(16), .GAP_CYCLES(4), .TIMEOUT_CYCLES(32)) dut (
    .clk_host    (clk),
    .ic_n        (ic_n),
    .wr          (wr_if),
    .bus         (bus_if),
    .level       (level),
    .busy        (busy),
    .timeout_err (timeout_err),
    .fsm_state   (fsm_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_bad    = 0;
  logic [10:0] exp_q[$];
  bit          ack_en    = 1'b0;
  int          ack_delay = 0;
  int          n_strobe  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // opl3 model: acks after ack_delay strobe cycles and scores every acknowledged write
  always @(negedge clk) begin : responder
    logic [10:0] e;
    if (!bus_if.cs_n && !bus_if.wr_n) begin
      if (ack_en && n_strobe >= ack_delay) begin
        bus_if.ack_host_wr = 1'b1;
        e = 11'h0;
        if (exp_q.size() > 0) e = exp_q.pop_front();
        check("bus_wr", {21'h0, 1'b1, bus_if.address, bus_if.din}, {21'h0, e});
      end else begin
        bus_if.ack_host_wr = 1'b0;
      end
      n_strobe++;
    end else begin
      bus_if.ack_host_wr = 1'b0;
      n_strobe = 0;
    end
  end

  // driver tasks (called at a negedge, return at a negedge)
  task automatic push(input logic b, input logic [7:0] r, input logic [7:0] d);
    int t = 0;
    wr_if.wr_valid = 1'b1;
    wr_if.wr_bank  = b;
    wr_if.wr_reg   = r;
    wr_if.wr_data  = d;
    while (!wr_if.wr_ready && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (!wr_if.wr_ready) check("push_wait", {31'h0, wr_if.wr_ready}, 32'h1);
    exp_q.push_back({1'b1, b, 1'b0, r});
    exp_q.push_back({1'b1, b, 1'b1, d});
    @(negedge clk);
    wr_if.wr_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int t = 0;
    while (busy && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check(tag, {31'h0, busy}, 32'h0);
  endtask

  task automatic wait_state(input wrq_state_t s, input string tag);
    int t = 0;
    while (fsm_state != s && t < 300) begin
      @(negedge clk);
      t++;
    end
    check(tag, {31'h0, fsm_state == s}, 32'h1);
  endtask

  task automatic run_len(input logic v, output int len);
    len = 0;
    while (bus_if.cs_n == v && len < 200) begin
      len++;
      @(negedge clk);
    end
  endtask

  int len;
  int lows;

  initial begin
    ic_n               = 1'b0;
    wr_if.wr_valid     = 1'b0;
    wr_if.wr_bank      = 1'b0;
    wr_if.wr_reg       = 8'h00;
    wr_if.wr_data      = 8'h00;
    bus_if.ack_host_wr = 1'b0;
    repeat (3) @(negedge clk);

    // reset values
    check("rst_ready",   {31'h0, wr_if.wr_ready},  32'h1);
    check("rst_cs_n",    {31'h0, bus_if.cs_n},     32'h1);
    check("rst_rd_n",    {31'h0, bus_if.rd_n},     32'h1);
    check("rst_wr_n",    {31'h0, bus_if.wr_n},     32'h1);
    check("rst_address", {30'h0, bus_if.address},  32'h0);
    check("rst_din",     {24'h0, bus_if.din},      32'h0);
    check("rst_level",   {27'h0, level},           32'h0);
    check("rst_busy",    {31'h0, busy},            32'h0);
    check("rst_tmo",     {31'h0, timeout_err},     32'h0);
    ic_n = 1'b1;
    repeat (2) @(negedge clk);

    // single write, ack in first strobe cycle: cycle-exact sequence
    ack_en = 1'b1; ack_delay = 0;
    push(1'b1, 8'h05, 8'h01);
    check("t1_level1", {27'h0, level}, 32'h1);
    check("t1_idle",   {31'h0, fsm_state == IDLE}, 32'h1);
    check("t1_busy",   {31'h0, busy}, 32'h1);
    check("t1_cs_pre", {31'h0, bus_if.cs_n}, 32'h1);
    @(negedge clk);
    check("t1_a_cs",   {31'h0, bus_if.cs_n}, 32'h0);
    check("t1_a_wr",   {31'h0, bus_if.wr_n}, 32'h0);
    check("t1_a_addr", {30'h0, bus_if.address}, 32'h2);
    check("t1_a_din",  {24'h0, bus_if.din}, 32'h05);
    check("t1_level0", {27'h0, level}, 32'h0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t1_gapa_cs", {31'h0, bus_if.cs_n}, 32'h1);
    end
    check("t1_gapa_hold", {22'h0, bus_if.address, bus_if.din}, {22'h0, 2'b10, 8'h05});
    @(negedge clk);
    check("t1_d_cs",   {31'h0, bus_if.cs_n}, 32'h0);
    check("t1_d_addr", {30'h0, bus_if.address}, 32'h3);
    check("t1_d_din",  {24'h0, bus_if.din}, 32'h01);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t1_gapd_cs", {31'h0, bus_if.cs_n}, 32'h1);
    end
    check("t1_busy_10", {31'h0, busy}, 32'h1);
    @(negedge clk);
    check("t1_busy_11", {31'h0, busy}, 32'h0);
    check("t1_sb_left", exp_q.size(), 32'h0);

    // fill with acks held off, then drain in order
    ack_en = 1'b0;
    for (int i = 0; i < 17; i++) push(i[0], 8'h10 + 8'(i), 8'hA0 + 8'(i));
    check("t2_level16", {27'h0, level}, 32'd16);
    check("t2_full",    {31'h0, wr_if.wr_ready}, 32'h0);
    wr_if.wr_valid = 1'b1;
    wr_if.wr_bank  = 1'b1;
    wr_if.wr_reg   = 8'h3C;
    wr_if.wr_data  = 8'hC3;
    repeat (5) @(negedge clk);
    check("t2_held", {27'h0, level}, 32'd16);
    ack_en = 1'b1;
    push(1'b1, 8'h3C, 8'hC3);
    wait_idle("t2_drain");
    check("t2_sb_left", exp_q.size(), 32'h0);
    check("t2_ready",   {31'h0, wr_if.wr_ready}, 32'h1);

    // ack delayed 7 cycles in each phase
    ack_delay = 7;
    push(1'b0, 8'h40, 8'h7E);
    run_len(1'b1, len);
    run_len(1'b0, len);
    check("t3_addr_low", len, 32'd8);
    run_len(1'b1, len);
    check("t3_gap", len, 32'd4);
    run_len(1'b0, len);
    check("t3_data_low", len, 32'd8);
    wait_idle("t3_drain");
    check("t3_sb_left", exp_q.size(), 32'h0);

    // simultaneous push and pop at level 3
    ack_delay = 0; ack_en = 1'b0;
    for (int i = 0; i < 4; i++) push(1'b0, 8'h50 + 8'(i), 8'h60 + 8'(i));
    check("t4_level3", {27'h0, level}, 32'd3);
    ack_en = 1'b1;
    wait_state(IDLE, "t4_idle_wait");
    check("t4_level3_idle", {27'h0, level}, 32'd3);
    wr_if.wr_valid = 1'b1;
    wr_if.wr_bank  = 1'b1;
    wr_if.wr_reg   = 8'h99;
    wr_if.wr_data  = 8'h66;
    exp_q.push_back({1'b1, 1'b1, 1'b0, 8'h99});
    exp_q.push_back({1'b1, 1'b1, 1'b1, 8'h66});
    @(negedge clk);
    wr_if.wr_valid = 1'b0;
    check("t4_level_same", {27'h0, level}, 32'd3);
    check("t4_addr_state", {31'h0, fsm_state == ADDR}, 32'h1);
    wait_idle("t4_drain");
    check("t4_sb_left", exp_q.size(), 32'h0);

    // reset during DATA with 5 queued
    ack_delay = 1;
    for (int i = 0; i < 6; i++) push(1'b1, 8'h80 + 8'(i), 8'h90 + 8'(i));
    wait_state(DATA, "t6_data_wait");
    check("t6_level5", {27'h0, level}, 32'd5);
    ack_en = 1'b0;
    ic_n   = 1'b0;
    exp_q.delete();
    #1;
    check("t6_cs_n",  {31'h0, bus_if.cs_n}, 32'h1);
    check("t6_wr_n",  {31'h0, bus_if.wr_n}, 32'h1);
    check("t6_rd_n",  {31'h0, bus_if.rd_n}, 32'h1);
    check("t6_level", {27'h0, level}, 32'h0);
    check("t6_busy",  {31'h0, busy}, 32'h0);
    repeat (2) @(negedge clk);
    ic_n = 1'b1;
    lows = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!bus_if.cs_n || !bus_if.wr_n) lows++;
    end
    check("t6_no_strobe", lows, 32'h0);
    check("t6_level_rel", {27'h0, level}, 32'h0);
    ack_en = 1'b1; ack_delay = 0;
    push(1'b0, 8'hB4, 8'h1F);
    wait_idle("t6_drain");
    check("t6_sb_left", exp_q.size(), 32'h0);

`ifdef OPL3_WR_QUEUE_TIMEOUT_EN
    // ack never arrives: abort after 32 strobe cycles, flag is sticky
    ack_en = 1'b0;
    push(1'b1, 8'hE0, 8'h0E);
    void'(exp_q.pop_back());
    void'(exp_q.pop_back());
    run_len(1'b1, len);
    run_len(1'b0, len);
    check("t5_strobe_len", len, 32'd32);
    check("t5_tmo_set",    {31'h0, timeout_err}, 32'h1);
    check("t5_gap_d",      {31'h0, fsm_state == GAP_D}, 32'h1);
    ack_en = 1'b1;
    push(1'b0, 8'hE1, 8'h1E);
    wait_idle("t5_drain");
    check("t5_sb_left", exp_q.size(), 32'h0);
    check("t5_tmo_sticky", {31'h0, timeout_err}, 32'h1);
    ic_n = 1'b0;
    @(negedge clk);
    ic_n = 1'b1;
    @(negedge clk);
    check("t5_tmo_clear", {31'h0, timeout_err}, 32'h0);
`else
    check("tmo_tied", {31'h0, timeout_err}, 32'h0);
`endif

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
